// File: rtl/mi_fetch_ctrl.sv
// Fetch-stage controller: sequences the fetch PC, issues synchronous imem reads and
// buffers returning words in an output register plus one skid entry for the decoder.
module mi_fetch_ctrl #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  NOP      = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             dec_pc_en,
    output logic             en,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] instr_out,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        REDIR = 2'b10
    } state_e;

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] fpc_q,        fpc_d;
    logic             inflight_q,   inflight_d;
    logic [WIDTH-1:0] rsp_pc_q,     rsp_pc_d;
    logic             en_q,         en_d;
    logic [WIDTH-1:0] pc_out_q,     pc_out_d;
    logic [WIDTH-1:0] instr_q,      instr_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_pc_q,    skid_pc_d;
    logic [WIDTH-1:0] skid_instr_q, skid_instr_d;

    logic       accept;
    logic       out_free;
    logic [2:0] count;
    logic       req;

    // Occupancy after this edge, excluding any request issued now; capped at two
    // so a returning word always has a slot (output or skid).
    always_comb begin
        accept   = en_q & dec_pc_en;
        out_free = ~en_q | accept;
        count    = 3'(en_q) + 3'(skid_valid_q) + 3'(inflight_q) - 3'(accept);
        req      = ~rst & (state_q == RUN) & fetch_en & ~redirect_valid & (count < 3'd2);
    end

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        inflight_d   = 1'b0;
        rsp_pc_d     = rsp_pc_q;
        en_d         = en_q;
        pc_out_d     = pc_out_q;
        instr_d      = instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (redirect_valid) begin
            state_d = REDIR;
        end else begin
            unique case (state_q)
                IDLE:    state_d = fetch_en ? RUN : IDLE;
                RUN:     state_d = fetch_en ? RUN : IDLE;
                REDIR:   state_d = fetch_en ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (req) begin
            fpc_d      = fpc_q + WIDTH'(4);
            inflight_d = 1'b1;
            rsp_pc_d   = fpc_q;
        end

        if (redirect_valid) begin
            // The response landing this cycle belongs to the old stream and is dropped.
            fpc_d        = redirect_pc;
            en_d         = 1'b0;
            instr_d      = NOP;
            skid_valid_d = 1'b0;
            inflight_d   = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                en_d     = 1'b1;
                pc_out_d = skid_pc_q;
                instr_d  = skid_instr_q;
                if (inflight_q) begin
                    skid_pc_d    = rsp_pc_q;
                    skid_instr_d = imem_rdata;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (inflight_q) begin
                en_d     = 1'b1;
                pc_out_d = rsp_pc_q;
                instr_d  = imem_rdata;
            end else if (accept) begin
                en_d    = 1'b0;
                instr_d = NOP;
            end
        end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = rsp_pc_q;
            skid_instr_d = imem_rdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fpc_q        <= RESET_PC;
            inflight_q   <= 1'b0;
            rsp_pc_q     <= '0;
            en_q         <= 1'b0;
            pc_out_q     <= '0;
            instr_q      <= NOP;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            inflight_q   <= inflight_d;
            rsp_pc_q     <= rsp_pc_d;
            en_q         <= en_d;
            pc_out_q     <= pc_out_d;
            instr_q      <= instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign imem_req  = req;
    assign imem_addr = fpc_q;
    assign en        = en_q;
    assign pc_out    = pc_out_q;
    assign instr_out = instr_q;
    assign state     = state_q;

    skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inflight_q && skid_valid_q && en_q && !dec_pc_en && !redirect_valid));

    count_bounded: assert property (@(posedge clk) disable iff (rst)
        count <= 3'd2);

endmodule
